// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants and instruction field positions used by the
// issue buffer and the downstream control unit.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] NOP_OPCODE = 7'b0000000;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    typedef enum logic [1:0] {
        ST_PAIR,
        ST_SPLIT_A,
        ST_SPLIT_B
    } issue_state_t;

    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_ITYPE) || (opc == OPC_LOAD);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Circular buffer of fetch pairs {pc, instrB, instrA}; flush beats push and pop,
// and a push on a full buffer is ignored.
module pair_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_issue_buffer.sv
// Pair buffer and issue stage: splits a hazardous head pair into two issue
// beats and presents masked opcode/funct fields to the control unit.
module dual_issue_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            flush,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_instrA,
    input  logic [31:0]     fetch_instrB,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [XLEN-1:0] issue_pc,
    output logic            validA,
    output logic            validB,
    output logic [6:0]      opcodeA,
    output logic [6:0]      opcodeB,
    output logic [2:0]      funct3A,
    output logic [2:0]      funct3B,
    output logic [6:0]      funct7A,
    output logic [6:0]      funct7B,
    output logic [31:0]     instrA,
    output logic [31:0]     instrB
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = XLEN + 64;

    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_pop;
    logic [XLEN-1:0]    head_pc;
    logic [31:0]        head_a;
    logic [31:0]        head_b;
    logic               b_pending;
    logic               b_pending_next;
    logic               hazard;
    logic               handshake;
    issue_state_t       issue_state;

    assign fetch_ready = (fifo_count != CNT_W'(DEPTH));
    assign issue_valid = (fifo_count != '0);
    assign handshake   = issue_valid && issue_ready;
    assign {head_pc, head_b, head_a} = head_data;

    pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_pair_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fetch_valid && fetch_ready),
        .push_data ({fetch_pc, fetch_instrB, fetch_instrA}),
        .pop       (fifo_pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    // Only the head pair is inspected; hazards across entries are not possible
    // to split here and are left to the control unit.
    always_comb begin
        logic [4:0] rd_a;
        rd_a   = head_a[RD_MSB:RD_LSB];
        hazard = 1'b0;
        if (writes_rd(head_a[OPC_MSB:OPC_LSB]) && (rd_a != 5'd0) &&
            ((head_b[RS1_MSB:RS1_LSB] == rd_a) ||
             (reads_rs2(head_b[OPC_MSB:OPC_LSB]) && (head_b[RS2_MSB:RS2_LSB] == rd_a)))) begin
            hazard = 1'b1;
        end
        if ((head_a[OPC_MSB:OPC_LSB] == OPC_BRANCH) || (head_a[OPC_MSB:OPC_LSB] == OPC_JALR)) begin
            hazard = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_pending <= 1'b0;
        end else begin
            b_pending <= b_pending_next;
        end
    end

    always_comb begin
        issue_state    = ST_PAIR;
        b_pending_next = b_pending;
        fifo_pop       = 1'b0;
        issue_pc       = '0;
        validA         = 1'b0;
        validB         = 1'b0;
        instrA         = '0;
        instrB         = '0;

        if (b_pending) begin
            issue_state = ST_SPLIT_B;
        end else if (hazard && !mode) begin
            issue_state = ST_SPLIT_A;
        end

        if (issue_valid) begin
            issue_pc = head_pc;
            case (issue_state)
                ST_PAIR: begin
                    validA   = 1'b1;
                    validB   = 1'b1;
                    instrA   = head_a;
                    instrB   = head_b;
                    fifo_pop = handshake;
                end
                ST_SPLIT_A: begin
                    validA = 1'b1;
                    instrA = head_a;
                    if (handshake) begin
                        b_pending_next = 1'b1;
                    end
                end
                ST_SPLIT_B: begin
                    validB   = 1'b1;
                    instrB   = head_b;
                    fifo_pop = handshake;
                    if (handshake) begin
                        b_pending_next = 1'b0;
                    end
                end
                default: begin
                    validA = 1'b0;
                end
            endcase
        end

        if (flush) begin
            b_pending_next = 1'b0;
            fifo_pop       = 1'b0;
        end
    end

    assign opcodeA = validA ? instrA[OPC_MSB:OPC_LSB] : NOP_OPCODE;
    assign opcodeB = validB ? instrB[OPC_MSB:OPC_LSB] : NOP_OPCODE;
    assign funct3A = instrA[F3_MSB:F3_LSB];
    assign funct3B = instrB[F3_MSB:F3_LSB];
    assign funct7A = instrA[F7_MSB:F7_LSB];
    assign funct7B = instrB[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_dual_issue_buffer.sv
// Scoreboard bench for dual_issue_buffer: expected issue beats are queued at
// push time and compared as the buffer hands them downstream.
module tb_dual_issue_buffer;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic            flush;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     fetch_instrA;
    logic [31:0]     fetch_instrB;
    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] issue_pc;
    logic            validA;
    logic            validB;
    logic [6:0]      opcodeA;
    logic [6:0]      opcodeB;
    logic [2:0]      funct3A;
    logic [2:0]      funct3B;
    logic [6:0]      funct7A;
    logic [6:0]      funct7B;
    logic [31:0]     instrA;
    logic [31:0]     instrB;

    typedef struct {
        logic [63:0] pc;
        logic        va;
        logic        vb;
        logic [31:0] ia;
        logic [31:0] ib;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    modelCount;
    int    total;
    int    bad;

    dual_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_pc     (fetch_pc),
        .fetch_instrA (fetch_instrA),
        .fetch_instrB (fetch_instrB),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_pc     (issue_pc),
        .validA       (validA),
        .validB       (validB),
        .opcodeA      (opcodeA),
        .opcodeB      (opcodeB),
        .funct3A      (funct3A),
        .funct3B      (funct3B),
        .funct7A      (funct7A),
        .funct7B      (funct7B),
        .instrA       (instrA),
        .instrB       (instrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit benchHazard(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] oa;
        logic [6:0] ob;
        logic [4:0] rd;
        bit         wr;
        bit         useRs2;
        oa     = a[6:0];
        ob     = b[6:0];
        rd     = a[11:7];
        wr     = (oa == 7'h33) || (oa == 7'h13) || (oa == 7'h03);
        useRs2 = (ob == 7'h33) || (ob == 7'h23) || (ob == 7'h63);
        if (oa == 7'h63 || oa == 7'h67) return 1'b1;
        return wr && (rd != 5'd0) && ((b[19:15] == rd) || (useRs2 && (b[24:20] == rd)));
    endfunction

    // Mode is only changed while the buffer is empty, so mode at push time
    // equals mode at head evaluation.
    task automatic queuePair(input logic [63:0] pc, input logic [31:0] a, input logic [31:0] b);
        if (!mode && benchHazard(a, b)) begin
            sb.push_back('{pc: pc, va: 1'b1, vb: 1'b0, ia: a, ib: 32'd0, last: 1'b0});
            sb.push_back('{pc: pc, va: 1'b0, vb: 1'b1, ia: 32'd0, ib: b, last: 1'b1});
        end else begin
            sb.push_back('{pc: pc, va: 1'b1, vb: 1'b1, ia: a, ib: b, last: 1'b1});
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        bit    readyNow;
        if (!rst_n || flush) begin
            sb.delete();
            modelCount = 0;
        end else begin
            readyNow = (modelCount != DEPTH);
            checkOutput("issue_valid", {63'd0, issue_valid}, {63'd0, sb.size() != 0});
            checkOutput("fetch_ready", {63'd0, fetch_ready}, {63'd0, readyNow});
            if (issue_valid && issue_ready && sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("issue_pc", issue_pc, e.pc);
                checkOutput("validA", {63'd0, validA}, {63'd0, e.va});
                checkOutput("validB", {63'd0, validB}, {63'd0, e.vb});
                checkOutput("instrA", {32'd0, instrA}, {32'd0, e.ia});
                checkOutput("instrB", {32'd0, instrB}, {32'd0, e.ib});
                checkOutput("opcodeA", {57'd0, opcodeA}, {57'd0, e.ia[6:0]});
                checkOutput("opcodeB", {57'd0, opcodeB}, {57'd0, e.ib[6:0]});
                checkOutput("funct3A", {61'd0, funct3A}, {61'd0, e.ia[14:12]});
                checkOutput("funct3B", {61'd0, funct3B}, {61'd0, e.ib[14:12]});
                checkOutput("funct7A", {57'd0, funct7A}, {57'd0, e.ia[31:25]});
                checkOutput("funct7B", {57'd0, funct7B}, {57'd0, e.ib[31:25]});
                if (e.last) modelCount--;
            end
            if (fetch_valid && readyNow) begin
                queuePair(fetch_pc, fetch_instrA, fetch_instrB);
                modelCount++;
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] pc, input logic [31:0] a, input logic [31:0] b);
        fetch_valid  = 1'b1;
        fetch_pc     = pc;
        fetch_instrA = a;
        fetch_instrB = b;
        @(posedge clk);
        #1;
        fetch_valid  = 1'b0;
    endtask

    task automatic waitEmpty(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (i == bound) checkOutput("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] holdPc;
        logic [31:0] holdA;
        logic        holdVb;
        total = 0; bad = 0; modelCount = 0;
        rst_n = 1'b1; mode = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        fetch_pc = '0; fetch_instrA = '0; fetch_instrB = '0; issue_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_fetch_ready", {63'd0, fetch_ready}, 64'd1);
        checkOutput("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
        checkOutput("rst_valids", {62'd0, validA, validB}, 64'd0);
        checkOutput("rst_issue_pc", issue_pc, 64'd0);
        checkOutput("rst_instrA", {32'd0, instrA}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain pair: visible the cycle after the push
        issue_ready = 1'b1;
        applyStimulus(64'h100, 32'h003100B3, 32'h00628233);
        checkOutput("t1_issue_valid", {63'd0, issue_valid}, 64'd1);
        checkOutput("t1_opcodeA", {57'd0, opcodeA}, 64'h33);
        checkOutput("t1_opcodeB", {57'd0, opcodeB}, 64'h33);
        waitEmpty(20);

        // RAW split in mode 0, then unified in mode 1
        applyStimulus(64'h200, 32'h00100293, 32'h00528333);
        waitEmpty(20);
        @(posedge clk); #1;
        mode = 1'b1;
        applyStimulus(64'h208, 32'h00100293, 32'h00528333);
        waitEmpty(20);
        @(posedge clk); #1;
        mode = 1'b0;

        // Branch in slot A splits
        applyStimulus(64'h300, 32'h00000063, 32'h00628233);
        waitEmpty(20);

        // Backpressure: third pair refused, outputs hold
        issue_ready = 1'b0;
        applyStimulus(64'h400, 32'h003100B3, 32'h00628233);
        applyStimulus(64'h408, 32'h00100293, 32'h00528333);
        checkOutput("t4_full_ready", {63'd0, fetch_ready}, 64'd0);
        applyStimulus(64'h410, 32'h00000013, 32'h000000B3);
        holdPc = issue_pc; holdA = instrA; holdVb = validB;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_hold_pc", issue_pc, 64'h400);
        checkOutput("t4_hold_stable", {31'd0, (issue_pc == holdPc), holdA, holdVb},
                    {31'd0, 1'b1, 32'h003100B3, 1'b1});
        checkOutput("t4_hold_instrA", {32'd0, instrA}, {32'd0, holdA});
        issue_ready = 1'b1;
        waitEmpty(30);
        repeat (2) @(posedge clk);
        #1;

        // Flush with b_pending set and two entries
        issue_ready = 1'b0;
        applyStimulus(64'h500, 32'h00100293, 32'h00528333);
        applyStimulus(64'h508, 32'h003100B3, 32'h00628233);
        issue_ready = 1'b1;
        @(posedge clk); #1;
        issue_ready = 1'b0;
        checkOutput("t5_splitB", {62'd0, validA, validB}, 64'd1);
        checkOutput("t5_splitB_pc", issue_pc, 64'h500);
        flush = 1'b1;
        applyStimulus(64'h600, 32'h003100B3, 32'h00628233);
        flush = 1'b0;
        checkOutput("t5_flush_valid", {63'd0, issue_valid}, 64'd0);
        checkOutput("t5_flush_ready", {63'd0, fetch_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_flush_empty", {63'd0, issue_valid}, 64'd0);
        issue_ready = 1'b1;

        // rd=x0 never creates a RAW hazard
        applyStimulus(64'h700, 32'h00000013, 32'h000000B3);
        waitEmpty(20);

        // Async reset while in SPLIT_B
        issue_ready = 1'b0;
        applyStimulus(64'h800, 32'h00100293, 32'h00528333);
        issue_ready = 1'b1;
        @(posedge clk); #1;
        issue_ready = 1'b0;
        checkOutput("t6_pre_rst_validB", {63'd0, validB}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", {63'd0, issue_valid}, 64'd0);
        checkOutput("t6_rst_validB", {63'd0, validB}, 64'd0);
        checkOutput("t6_rst_pc", issue_pc, 64'd0);
        checkOutput("t6_rst_instrB", {32'd0, instrB}, 64'd0);
        checkOutput("t6_rst_opcodeB", {57'd0, opcodeB}, 64'd0);
        checkOutput("t6_rst_ready", {63'd0, fetch_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_after_rst", {63'd0, issue_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
